// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
//   Shared types and constants for the immediate/target pipeline.
//   - fmt_e      : 3-bit instruction format class (NONE/I/S/B/U/J).
//   - OP_*       : RV32I major opcodes (inst[6:0]).
//   - sext()     : sign-extends the low 'width' bits of a 32-bit field to
//                  MAX_XLEN bits; callers slice down to their own XLEN.
// -----------------------------------------------------------------------------
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_OP       = 7'b0110011;

    localparam int unsigned MAX_XLEN = 64;

    // Shift the field's sign bit up to bit 63, then arithmetic-shift back
    // down so the sign fills every bit above 'width'.
    function automatic logic [MAX_XLEN-1:0] sext(input logic [31:0] value,
                                                  input int unsigned width);
        logic signed [MAX_XLEN-1:0] wide;
        wide = $signed({32'd0, value} << (MAX_XLEN - width));
        return $unsigned(wide >>> (MAX_XLEN - width));
    endfunction

endpackage

// File: rtl/imm_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
//   Combinational instruction classifier and immediate generator.
//   Ports:
//     inst      in   32    raw instruction word
//     fmt       out  3     format class (fmt_e)
//     imm       out  XLEN  sign-extended immediate, 0 for NONE/illegal
//     illegal   out  1     opcode outside the RV32I map
//     is_jalr   out  1     JALR (target built from rs1)
//     is_auipc  out  1     AUIPC (target valid, never a misalign source)
// -----------------------------------------------------------------------------
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output fmt_e            fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal,
    output logic            is_jalr,
    output logic            is_auipc
);

    logic [MAX_XLEN-1:0] imm_wide;

    // NOTE: every output of a combinational block gets a default before the
    // case statement; a path that skips an assignment would infer a latch.
    always_comb begin
        fmt      = FMT_NONE;
        illegal  = 1'b0;
        is_jalr  = 1'b0;
        is_auipc = 1'b0;
        case (inst[6:0])
            OP_LOAD, OP_OP_IMM, OP_MISC_MEM, OP_SYSTEM: fmt = FMT_I;
            OP_JALR: begin
                fmt     = FMT_I;
                is_jalr = 1'b1;
            end
            OP_STORE:  fmt = FMT_S;
            OP_BRANCH: fmt = FMT_B;
            OP_LUI:    fmt = FMT_U;
            OP_AUIPC: begin
                fmt      = FMT_U;
                is_auipc = 1'b1;
            end
            OP_JAL:    fmt = FMT_J;
            OP_OP:     fmt = FMT_NONE;
            default:   illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm_wide = '0;
        case (fmt)
            FMT_I: imm_wide = sext({20'd0, inst[31:20]}, 12);
            FMT_S: imm_wide = sext({20'd0, inst[31:25], inst[11:7]}, 12);
            FMT_B: imm_wide = sext({19'd0, inst[31], inst[7], inst[30:25],
                                    inst[11:8], 1'b0}, 13);
            FMT_J: imm_wide = sext({11'd0, inst[31], inst[19:12], inst[20],
                                    inst[30:21], 1'b0}, 21);
            // U immediates already occupy bit 31; extension only matters
            // for a 64-bit datapath.
            FMT_U: imm_wide = sext({inst[31:12], 12'd0}, 32);
            default: imm_wide = '0;
        endcase
    end

    assign imm = imm_wide[XLEN-1:0];

endmodule

// File: rtl/imm_target_pipe.sv
// -----------------------------------------------------------------------------
// imm_target_pipe
//   Two-stage immediate-decode and control-flow-target unit.
//   Stage A holds the raw instruction, PC and rs1; stage B holds the decoded
//   format, immediate, target and flags. All outputs come from stage B flops.
//   Ports:
//     clk, rst        clock; synchronous active-high reset
//     flush           drop everything in flight (redirect)
//     in_valid/ready  upstream handshake; in_inst, in_pc, in_rs1 payload
//     out_valid/ready downstream handshake
//     out_fmt         format class (fmt_e)
//     out_imm         sign-extended immediate
//     out_target      pc+imm (B/JAL/AUIPC) or (rs1+imm)&~1 (JALR), else 0
//     out_tgt_vld     out_target is meaningful
//     out_misalign    branch/jump target violates IALIGN
//     out_illegal     opcode not in the RV32I map
// -----------------------------------------------------------------------------
module imm_target_pipe
    import imm_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    output logic            out_valid,
    input  logic            out_ready,
    output fmt_e            out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic            out_tgt_vld,
    output logic            out_misalign,
    output logic            out_illegal
);

    // Stage A
    logic            a_valid;
    logic [31:0]     a_inst;
    logic [XLEN-1:0] a_pc;
    logic [XLEN-1:0] a_rs1;

    // Stage B
    logic            b_valid;
    fmt_e            b_fmt;
    logic [XLEN-1:0] b_imm;
    logic [XLEN-1:0] b_target;
    logic            b_tgt_vld;
    logic            b_misalign;
    logic            b_illegal;

    // Decode / target datapath between the stages
    fmt_e            dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            dec_is_jalr;
    logic            dec_is_auipc;
    logic [XLEN-1:0] sum_base;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] target;
    logic            tgt_vld;
    logic            misalign;

    logic            a_ready;
    logic            b_ready;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst     (a_inst),
        .fmt      (dec_fmt),
        .imm      (dec_imm),
        .illegal  (dec_illegal),
        .is_jalr  (dec_is_jalr),
        .is_auipc (dec_is_auipc)
    );

    always_comb begin
        sum_base = dec_is_jalr ? a_rs1 : a_pc;
        sum      = sum_base + dec_imm;
        tgt_vld  = (dec_fmt == FMT_B) || (dec_fmt == FMT_J) ||
                   dec_is_jalr || dec_is_auipc;
        target   = '0;
        if (dec_is_jalr)
            target = {sum[XLEN-1:1], 1'b0};
        else if (tgt_vld)
            target = sum;
        // AUIPC produces an address, not a control transfer.
        misalign = (IALIGN == 32) && tgt_vld && !dec_is_auipc && target[1];
    end

    // Each stage can take new data when empty or when its content leaves
    // this cycle; the chain makes backpressure purely combinational.
    assign b_ready  = !b_valid || out_ready;
    assign a_ready  = !a_valid || b_ready;
    assign in_ready = a_ready && !flush && !rst;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are cleared on reset as well as the
            // valids, so outputs read as zero until the first result.
            a_valid    <= 1'b0;
            a_inst     <= '0;
            a_pc       <= '0;
            a_rs1      <= '0;
            b_valid    <= 1'b0;
            b_fmt      <= FMT_NONE;
            b_imm      <= '0;
            b_target   <= '0;
            b_tgt_vld  <= 1'b0;
            b_misalign <= 1'b0;
            b_illegal  <= 1'b0;
        end else if (flush) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else begin
            if (b_ready) begin
                b_valid <= a_valid;
                if (a_valid) begin
                    b_fmt      <= dec_fmt;
                    b_imm      <= dec_imm;
                    b_target   <= target;
                    b_tgt_vld  <= tgt_vld;
                    b_misalign <= misalign;
                    b_illegal  <= dec_illegal;
                end
            end
            if (a_ready) begin
                a_valid <= in_valid;
                if (in_valid) begin
                    a_inst <= in_inst;
                    a_pc   <= in_pc;
                    a_rs1  <= in_rs1;
                end
            end
        end
    end

    assign out_valid    = b_valid;
    assign out_fmt      = b_fmt;
    assign out_imm      = b_imm;
    assign out_target   = b_target;
    assign out_tgt_vld  = b_tgt_vld;
    assign out_misalign = b_misalign;
    assign out_illegal  = b_illegal;

endmodule

// File: tb/tb_imm_target_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_target_pipe
//   Directed bench for imm_target_pipe: reset, a table of single
//   instructions, backpressure, flush, mid-operation reset and a 64-bit
//   instance for U-immediate extension.
// -----------------------------------------------------------------------------
module tb_imm_target_pipe;
    import imm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, in_rs1, out_imm, out_target;
    logic        out_tgt_vld, out_misalign, out_illegal;
    fmt_e        out_fmt;

    // 64-bit instance
    logic        flush64, in_valid64, in_ready64, out_valid64, out_ready64;
    logic [31:0] in_inst64;
    logic [63:0] in_pc64, in_rs164, out_imm64, out_target64;
    logic        out_tgt_vld64, out_misalign64, out_illegal64;
    fmt_e        out_fmt64;

    imm_target_pipe #(.XLEN(32), .IALIGN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .in_rs1(in_rs1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fmt(out_fmt), .out_imm(out_imm), .out_target(out_target),
        .out_tgt_vld(out_tgt_vld), .out_misalign(out_misalign),
        .out_illegal(out_illegal)
    );

    imm_target_pipe #(.XLEN(64), .IALIGN(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush64),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .in_inst(in_inst64), .in_pc(in_pc64), .in_rs1(in_rs164),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .out_fmt(out_fmt64), .out_imm(out_imm64), .out_target(out_target64),
        .out_tgt_vld(out_tgt_vld64), .out_misalign(out_misalign64),
        .out_illegal(out_illegal64)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1;
        fmt_e        fmt;
        logic [31:0] imm;
        logic [31:0] tgt;
        logic        tv;
        logic        mis;
        logic        ill;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    int  sent, recv, seen;
    logic fire_in;

    initial begin
        //            inst          pc            rs1           fmt       imm           target        tv    mis   ill
        vecs[0]  = '{32'hFE000EE3, 32'h00000100, 32'h0,        FMT_B,    32'hFFFFFFFC, 32'h000000FC, 1'b1, 1'b0, 1'b0}; // beq -4
        vecs[1]  = '{32'hFE000E63, 32'h00000100, 32'h0,        FMT_B,    32'hFFFFF7FC, 32'hFFFFF8FC, 1'b1, 1'b0, 1'b0}; // inst[7]=0 -> imm[11]=0
        vecs[2]  = '{32'h800002B7, 32'h00000040, 32'h0,        FMT_U,    32'h80000000, 32'h0,        1'b0, 1'b0, 1'b0}; // lui
        vecs[3]  = '{32'h00308067, 32'h00000500, 32'h00001000, FMT_I,    32'h00000003, 32'h00001002, 1'b1, 1'b1, 1'b0}; // jalr +3
        vecs[4]  = '{32'hFE112E23, 32'h0,        32'h0,        FMT_S,    32'hFFFFFFFC, 32'h0,        1'b0, 1'b0, 1'b0}; // sw -4
        vecs[5]  = '{32'h7FF00093, 32'h0,        32'h0,        FMT_I,    32'h000007FF, 32'h0,        1'b0, 1'b0, 1'b0}; // addi +2047
        vecs[6]  = '{32'h80000093, 32'h0,        32'h0,        FMT_I,    32'hFFFFF800, 32'h0,        1'b0, 1'b0, 1'b0}; // addi -2048
        vecs[7]  = '{32'h008000EF, 32'h00000200, 32'h0,        FMT_J,    32'h00000008, 32'h00000208, 1'b1, 1'b0, 1'b0}; // jal +8
        vecs[8]  = '{32'h002000EF, 32'h00000200, 32'h0,        FMT_J,    32'h00000002, 32'h00000202, 1'b1, 1'b1, 1'b0}; // jal +2
        vecs[9]  = '{32'h00001517, 32'h00000302, 32'h0,        FMT_U,    32'h00001000, 32'h00001302, 1'b1, 1'b0, 1'b0}; // auipc, bit1 set, no misalign
        vecs[10] = '{32'h002081B3, 32'h0,        32'h0,        FMT_NONE, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0}; // add
        vecs[11] = '{32'hFE000EE3, 32'h00000002, 32'h0,        FMT_B,    32'hFFFFFFFC, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0}; // wrap below 0
        vecs[12] = '{32'hFFF08067, 32'h0,        32'h0,        FMT_I,    32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0}; // jalr -1, lsb cleared
        vecs[13] = '{32'h0000007F, 32'h0,        32'h0,        FMT_NONE, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1}; // illegal
        vecs[14] = '{32'h00000073, 32'h0,        32'h0,        FMT_I,    32'h0,        32'h0,        1'b0, 1'b0, 1'b0}; // ecall
        vecs[15] = '{32'hFFF02083, 32'h0,        32'h0,        FMT_I,    32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0}; // lw -1
        vecs[16] = '{32'h0000000F, 32'h0,        32'h0,        FMT_I,    32'h0,        32'h0,        1'b0, 1'b0, 1'b0}; // fence

        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00100093; in_pc = '0; in_rs1 = '0;
        out_ready = 1'b1;
        flush64 = 1'b0; in_valid64 = 1'b0; in_inst64 = '0;
        in_pc64 = '0; in_rs164 = '0; out_ready64 = 1'b1;

        // Reset held two cycles with an instruction offered.
        for (int c = 0; c < 2; c++) begin
            step();
            check($sformatf("rst_out_valid_c%0d", c), out_valid, 1'b0);
            check($sformatf("rst_out_imm_c%0d", c), out_imm, 32'h0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready_after_release", in_ready, 1'b1);
        step();
        check("rst_nothing_captured", out_valid, 1'b0);

        // Table: each instruction alone, fixed two-cycle latency.
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            in_pc    = vecs[i].pc;
            in_rs1   = vecs[i].rs1;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            check($sformatf("v%0d_valid_early", i), out_valid, 1'b0);
            step();
            check($sformatf("v%0d_valid", i),    out_valid,    1'b1);
            check($sformatf("v%0d_fmt", i),      out_fmt,      vecs[i].fmt);
            check($sformatf("v%0d_imm", i),      out_imm,      vecs[i].imm);
            check($sformatf("v%0d_target", i),   out_target,   vecs[i].tgt);
            check($sformatf("v%0d_tgt_vld", i),  out_tgt_vld,  vecs[i].tv);
            check($sformatf("v%0d_misalign", i), out_misalign, vecs[i].mis);
            check($sformatf("v%0d_illegal", i),  out_illegal,  vecs[i].ill);
        end
        step();  // drain the last result

        // Backpressure: five addi with imm 1..5, out_ready low for 6 cycles.
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
            out_ready = (cyc >= 6);
            in_valid  = (sent < 5);
            in_inst   = (32'(sent + 1) << 20) | 32'h00000093;
            in_pc     = '0;
            in_rs1    = '0;
            #1;
            if (cyc == 6)
                check("bp_accepts_before_release", sent, 2);
            if (cyc >= 2 && cyc < 6) begin
                check($sformatf("bp_in_ready_low_c%0d", cyc), in_ready, 1'b0);
                check($sformatf("bp_hold_imm_c%0d", cyc), out_imm, 32'h1);
            end
            fire_in = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check($sformatf("bp_order%0d", recv), out_imm, 32'(recv + 1));
                recv++;
            end
            step();
            if (fire_in)
                sent++;
        end
        check("bp_all_received", recv, 5);
        in_valid = 1'b0;
        step();
        check("bp_no_duplicate", out_valid, 1'b0);

        // Flush with two entries in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00308067; in_rs1 = 32'h1000;
        step();
        in_inst   = 32'h800002B7;
        step();
        check("fl_two_inflight", out_valid, 1'b1);
        flush   = 1'b1;
        in_inst = 32'h7FF00093;
        #1;
        check("fl_in_ready_low", in_ready, 1'b0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid_cleared", out_valid, 1'b0);
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (out_valid)
                seen++;
        end
        check("fl_nothing_emerges", seen, 0);

        // Pipe still works after flush: illegal opcode.
        in_valid = 1'b1; in_inst = 32'h0000007F;
        step();
        in_valid = 1'b0;
        step();
        check("fl_post_valid",   out_valid,   1'b1);
        check("fl_post_illegal", out_illegal, 1'b1);
        check("fl_post_fmt",     out_fmt,     FMT_NONE);
        check("fl_post_imm",     out_imm,     32'h0);
        step();

        // Reset mid-operation clears valids and data.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_inst = 32'h800002B7;
        step();
        in_valid  = 1'b0;
        step();
        check("mr_loaded_imm", out_imm, 32'h80000000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_out_valid", out_valid, 1'b0);
        check("mr_out_imm",   out_imm,   32'h0);
        check("mr_out_fmt",   out_fmt,   FMT_NONE);
        out_ready = 1'b1;
        step();
        check("mr_stays_empty", out_valid, 1'b0);

        // 64-bit datapath: U immediates sign-extend from bit 31.
        in_valid64 = 1'b1; in_inst64 = 32'h800002B7; in_pc64 = 64'h0;
        step();
        in_valid64 = 1'b1; in_inst64 = 32'h80000017; in_pc64 = 64'h1000;
        step();
        in_valid64 = 1'b0;
        check("x64_lui_valid",   out_valid64,   1'b1);
        check("x64_lui_imm",     out_imm64,     64'hFFFFFFFF80000000);
        check("x64_lui_tgt_vld", out_tgt_vld64, 1'b0);
        step();
        check("x64_auipc_valid",  out_valid64,  1'b1);
        check("x64_auipc_imm",    out_imm64,    64'hFFFFFFFF80000000);
        check("x64_auipc_target", out_target64, 64'hFFFFFFFF80001000);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
